// File: rtl/bcd_scan_decoder_pkg.sv
// Shared widths and limits for the scanned BCD decoder.
package bcd_scan_decoder_pkg;
  localparam int BCD_W   = 4;
  localparam int DEC_W   = 10;
  localparam int BCD_MAX = 9;
endpackage

// File: rtl/bcd_scan_decoder_if.sv
// Digit snapshot inputs and scanned display outputs of the BCD scan decoder.
interface bcd_scan_decoder_if
  import bcd_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();
  logic [BCD_W*NUM_DIGITS-1:0] bcd_in;
  logic                        load;
  logic                        blank_lz;
  logic [DEC_W-1:0]            dec_out;
  logic [NUM_DIGITS-1:0]       dig_sel;
  logic                        invalid_out;
  logic                        err_sticky;
  logic                        frame_done;

  modport master (
    output bcd_in, load, blank_lz,
    input  dec_out, dig_sel, invalid_out, err_sticky, frame_done
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output dec_out, dig_sel, invalid_out, err_sticky, frame_done
  );
endinterface

// File: rtl/bcd_scan_decoder_digit_decode.sv
// One BCD digit to one-hot decimal; codes above 9 give no one-hot bit and raise invalid.
module bcd_digit_decode
  import bcd_scan_decoder_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [DEC_W-1:0] dec,
  output logic             invalid
);
  always_comb begin
    dec     = '0;
    invalid = 1'b0;
    if (digit <= BCD_W'(BCD_MAX))
      dec = DEC_W'(1) << digit;
    else
      invalid = 1'b1;
  end
endmodule

// File: rtl/bcd_scan_decoder.sv
// Scans a snapshot of NUM_DIGITS BCD digits at a prescaled rate, driving one-hot
// decimal and digit select with invalid detection and optional leading-zero blanking.
module bcd_scan_decoder
  import bcd_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input logic                 clk,
  input logic                 rst,
  bcd_scan_decoder_if.slave   bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [BCD_W*NUM_DIGITS-1:0] snapshot;
  logic [PS_W-1:0]             ps_cnt;
  logic [IDX_W-1:0]            idx;
  logic                        tick;

  logic [BCD_W-1:0]      digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [BCD_W-1:0]      cur_digit;
  logic [DEC_W-1:0]      cur_dec;
  logic                  cur_invalid;
  logic                  blank;

  logic [DEC_W-1:0]      dec_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  invalid_q;
  logic                  err_q;
  logic                  frame_q;

  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      digits[i] = snapshot[i*BCD_W +: BCD_W];
  end

  // lz_mask[i] is set while digits NUM_DIGITS-1..i are all zero; an invalid code ends the run
  always_comb begin
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run & (digits[i] == '0);
      lz_mask[i] = run;
    end
  end

  assign cur_digit = digits[idx];
  assign blank     = bus.blank_lz & lz_mask[idx] & (idx != '0);

  bcd_digit_decode u_decode (
    .digit   (cur_digit),
    .dec     (cur_dec),
    .invalid (cur_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot  <= '0;
      ps_cnt    <= '0;
      idx       <= '0;
      dec_q     <= '0;
      sel_q     <= '0;
      invalid_q <= 1'b0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (bus.load)
        snapshot <= bus.bcd_in;

      if (tick)
        ps_cnt <= '0;
      else
        ps_cnt <= ps_cnt + PS_W'(1);

      frame_q <= 1'b0;
      if (tick) begin
        dec_q     <= blank ? '0 : cur_dec;
        invalid_q <= blank ? 1'b0 : cur_invalid;
        sel_q     <= NUM_DIGITS'(1) << idx;
        frame_q   <= (idx == IDX_W'(NUM_DIGITS - 1));
        if (idx == IDX_W'(NUM_DIGITS - 1))
          idx <= '0;
        else
          idx <= idx + IDX_W'(1);
      end

      // A tick showing an invalid digit outranks a clearing load on the same edge
      if (tick && !blank && cur_invalid)
        err_q <= 1'b1;
      else if (bus.load)
        err_q <= 1'b0;
    end
  end

  assign bus.dec_out     = dec_q;
  assign bus.dig_sel     = sel_q;
  assign bus.invalid_out = invalid_q;
  assign bus.err_sticky  = err_q;
  assign bus.frame_done  = frame_q;
endmodule

// File: doc/bcd_scan_decoder.md
Name: bcd_scan_decoder

Overview:
- Parametrised successor to the team's single-digit BCD-to-decimal decoder.
- Holds a snapshot of NUM_DIGITS packed BCD digits and scans them one at a time at a prescaled rate.
- For each scanned digit it drives a registered one-hot decimal code plus a one-hot digit select.
- Adds invalid-code detection (10-15), a sticky error flag and optional leading-zero blanking; feeds multiplexed display/indicator drivers.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (>=1).
- PRESCALE, 1000, clock cycles per digit slot (>=1; 1 = new digit every cycle).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bcd_in  in  4*NUM_DIGITS  packed digits; digit i = bcd_in[4i+3:4i]; digit 0 least significant.
- load  in  1  capture bcd_in into snapshot on this edge.
- blank_lz  in  1  1 = blank leading zeros.
- dec_out  out  10  one-hot decimal of current digit; bit k = value k.
- dig_sel  out  NUM_DIGITS  one-hot select of digit currently shown.
- invalid_out  out  1  current shown digit is 10-15.
- err_sticky  out  1  an invalid digit was shown since the last load/reset.
- frame_done  out  1  one-cycle pulse on the tick that shows digit NUM_DIGITS-1.

Behaviour:
- Reset (async, immediate): snapshot=0, prescaler=0, idx=0; dec_out=0, dig_sel=0, invalid_out=0, err_sticky=0, frame_done=0.
- Prescaler counts 0..PRESCALE-1 and wraps. tick = (count==PRESCALE-1). The first tick occurs PRESCALE cycles after reset release.
- On tick, the output registers take the decode of snapshot digit[idx]:
  - dig_sel = 1<<idx.
  - idx then advances, wrapping NUM_DIGITS-1 -> 0.
  - frame_done=1 iff idx==NUM_DIGITS-1; otherwise frame_done=0.
- Between ticks all outputs hold, except frame_done, which is 0.
- Decode of digit d:
  - d<=9: dec_out=1<<d, invalid_out=0.
  - d>=10: dec_out=0, invalid_out=1.
- Leading-zero blanking:
  - When blank_lz=1, digit i>0 is blanked if digits NUM_DIGITS-1..i are all 0.
  - Blanked: dec_out=0, invalid_out=0, dig_sel still asserted.
  - Digit 0 is never blanked. An invalid digit is non-zero and ends the zero run.
  - blank_lz is sampled at the tick.
- load:
  - Snapshot updates on the edge where load=1. Scan position and prescaler are unaffected.
  - A tick on the same edge uses the old snapshot. The new value is first visible on the next tick.
- err_sticky:
  - Set on a tick that shows an invalid digit.
  - Cleared on an edge with load=1.
  - If load and an invalid-showing tick coincide, set wins.
- Widths:
  - idx width = max(1, clog2(NUM_DIGITS)).
  - Prescaler width = max(1, clog2(PRESCALE)).
  - No arithmetic overflow is possible; counters use explicit wrap compares, never power-of-two rollover.
- Reset mid-scan: outputs zero immediately. Scanning restarts from digit 0 with a full PRESCALE wait.

Decomposition:
- Shared package: BCD_W=4, DEC_W=10, BCD_MAX=9.
- One sub-module, bcd_digit_decode: combinational 4-bit -> 10-bit one-hot plus invalid flag. Instantiated once on the muxed digit.
- Leading-zero mask (NUM_DIGITS bits) is computed combinationally from the snapshot in the top level.

Test Plan:
- NUM_DIGITS=4, PRESCALE=4: reset, load bcd_in=16'h1234 -> ticks at cycles 4,8,12,16 show:
  - dec_out 10'h010 / dig_sel 4'b0001;
  - 10'h008 / 4'b0010;
  - 10'h004 / 4'b0100;
  - 10'h002 / 4'b1000 with frame_done=1 for one cycle only.
- blank_lz=1, load 16'h0050 -> digit0 shows 10'h001, digit1 shows 10'h020, digits 2,3 show dec_out=0 with dig_sel asserted. Load 16'h0000 -> only digit0 shows 10'h001.
- Load 16'h12A4:
  - digit1 tick shows dec_out=0, invalid_out=1, err_sticky=1.
  - err_sticky stays 1 across subsequent frames.
  - A following load of 16'h1234 clears it on that edge.
- Drive load with 16'h5678 on the same edge as the digit1 tick while snapshot=16'h1234 -> that tick shows 10'h008 (old). Next tick (digit2) shows 10'h040 (new 6).
- Assert rst asynchronously mid-slot (between edges) while dig_sel=4'b0100 -> all outputs 0 before the next edge. After release, the first tick is PRESCALE cycles later and shows digit0.
- NUM_DIGITS=1, PRESCALE=1: load 4'h7 -> from the second cycle after load, dec_out=10'h080 and dig_sel=1 every cycle. frame_done is 1 on every cycle.
